alu_nibble_sequencer: RTL and testbench

//  Multi-pass controller sequencing one combinational SLICE-bit ALU slice (add/sub, logic, shift,

---
 rtl/alu_nibble_sequencer.sv | 160 ++++++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer.sv
// Runs WIDTH-bit ALU operations through one external SLICE-bit combinational slice, least-significant
// slice first, chaining carry, serial shift bits and the unsigned compare result between passes.
module alu_nibble_sequencer #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_carry,
    output logic             out_lt,
    output logic             out_eq,
    output logic             out_gt,
    output logic [2:0]       slice_op,
    output logic [SLICE-1:0] slice_a,
    output logic [SLICE-1:0] slice_b,
    output logic             slice_cin,
    output logic             slice_sin,
    input  logic [SLICE-1:0] slice_y,
    input  logic             slice_cout,
    input  logic             slice_lt,
    input  logic             slice_eq,
    input  logic             slice_gt
);
    localparam int PASSES = WIDTH / SLICE;
    localparam int KW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int SELW   = $clog2(WIDTH);
    localparam int EXTW   = $clog2(WIDTH + 1);
    localparam logic [KW-1:0] LAST_PASS = KW'(PASSES - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [KW-1:0]    k;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic             carry;
    logic             lt;
    logic             eq;
    logic             gt;
    logic             accept;
    logic             last;
    logic             arith;
    logic [SELW-1:0]  lo;
    logic [EXTW-1:0]  shl_idx;
    logic [EXTW-1:0]  shr_idx;
    logic [WIDTH:0]   shl_src;
    logic [WIDTH:0]   shr_src;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && in_valid;
    assign last   = (k == LAST_PASS);
    assign arith  = (op == OP_ADD) || (op == OP_SUB);

    // Shift sources padded with a zero so the first SHL pass and last SHR pass pick up a 0 serial bit.
    always_comb begin
        lo        = SELW'(int'(k) * SLICE);
        shl_idx   = EXTW'(int'(k) * SLICE);
        shr_idx   = EXTW'((int'(k) + 1) * SLICE);
        shl_src   = {a, 1'b0};
        shr_src   = {1'b0, a};
        slice_op  = '0;
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;
        slice_sin = 1'b0;
        if (state == RUN) begin
            slice_op = op;
            slice_a  = a[lo +: SLICE];
            slice_b  = b[lo +: SLICE];
            if (k == '0) slice_cin = (op == OP_SUB);
            else         slice_cin = arith & carry;
            if (op == OP_SHL)      slice_sin = shl_src[shl_idx];
            else if (op == OP_SHR) slice_sin = shr_src[shr_idx];
        end
    end

    // A more significant differing slice overrides the compare result of the lower ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            k     <= '0;
            op    <= '0;
            a     <= '0;
            b     <= '0;
            y     <= '0;
            carry <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
        end else if (accept) begin
            k     <= '0;
            op    <= in_op;
            a     <= in_a;
            b     <= in_b;
            carry <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b1;
            gt    <= 1'b0;
        end else if (state == RUN) begin
            y[lo +: SLICE] <= slice_y;
            if (arith)             carry <= slice_cout;
            else if (op == OP_SHL) carry <= a[WIDTH-1];
            else if (op == OP_SHR) carry <= a[0];
            else                   carry <= 1'b0;
            if (!slice_eq) begin
                lt <= slice_lt;
                eq <= 1'b0;
                gt <= slice_gt;
            end
            if (last) k <= '0;
            else      k <= k + KW'(1);
        end
    end

    assign out_y     = y;
    assign out_carry = carry;
    assign out_lt    = lt;
    assign out_eq    = eq;
    assign out_gt    = gt;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: provides a behavioural 4-bit slice, a full-width reference model
// with a pending-op queue, and directed vectors with hand-computed results.
module tb_alu_nibble_sequencer;
    localparam int WIDTH = 8;
    localparam int SLICE = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_y;
    logic             out_carry;
    logic             out_lt;
    logic             out_eq;
    logic             out_gt;
    logic [2:0]       slice_op;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic             slice_cin;
    logic             slice_sin;
    logic [SLICE-1:0] slice_y;
    logic             slice_cout;
    logic             slice_lt;
    logic             slice_eq;
    logic             slice_gt;
    logic [SLICE:0]   slice_sum;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             c;
        logic             lt;
        logic             eq;
        logic             gt;
    } res_t;

    res_t expq[$];

    alu_nibble_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_carry(out_carry),
        .out_lt(out_lt), .out_eq(out_eq), .out_gt(out_gt),
        .slice_op(slice_op), .slice_a(slice_a), .slice_b(slice_b),
        .slice_cin(slice_cin), .slice_sin(slice_sin), .slice_y(slice_y), .slice_cout(slice_cout),
        .slice_lt(slice_lt), .slice_eq(slice_eq), .slice_gt(slice_gt)
    );

    always #5 clk = ~clk;

    // The ALU slice the controller drives.
    always_comb begin
        slice_sum  = '0;
        slice_y    = '0;
        slice_cout = 1'b0;
        case (slice_op)
            3'd0: begin
                slice_sum  = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, slice_cin};
                slice_y    = slice_sum[SLICE-1:0];
                slice_cout = slice_sum[SLICE];
            end
            3'd1: begin
                slice_sum  = {1'b0, slice_a} + {1'b0, ~slice_b} + {{SLICE{1'b0}}, slice_cin};
                slice_y    = slice_sum[SLICE-1:0];
                slice_cout = slice_sum[SLICE];
            end
            3'd2: slice_y = slice_a & slice_b;
            3'd3: slice_y = slice_a | slice_b;
            3'd4: slice_y = slice_a ^ slice_b;
            3'd5: slice_y = ~slice_a;
            3'd6: begin
                slice_y    = {slice_a[SLICE-2:0], slice_sin};
                slice_cout = slice_a[SLICE-1];
            end
            default: begin
                slice_y    = {slice_sin, slice_a[SLICE-1:1]};
                slice_cout = slice_a[0];
            end
        endcase
        slice_lt = (slice_a < slice_b);
        slice_eq = (slice_a == slice_b);
        slice_gt = (slice_a > slice_b);
    end

    function automatic res_t model(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        res_t           r;
        logic [WIDTH:0] w;
        r = '0;
        w = '0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; r.y = w[WIDTH-1:0]; r.c = w[WIDTH]; end
            3'd1: begin w = {1'b0, a} - {1'b0, b}; r.y = w[WIDTH-1:0]; r.c = (a >= b); end
            3'd2: r.y = a & b;
            3'd3: r.y = a | b;
            3'd4: r.y = a ^ b;
            3'd5: r.y = ~a;
            3'd6: begin w = {a, 1'b0}; r.y = w[WIDTH-1:0]; r.c = a[WIDTH-1]; end
            default: begin r.y = {1'b0, a[WIDTH-1:1]}; r.c = a[0]; end
        endcase
        r.lt = (a < b);
        r.eq = (a == b);
        r.gt = (a > b);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Record accepted ops and retire delivered results at the clock edge.
    always @(posedge clk) begin
        if (rst) begin
            expq.delete();
        end else begin
            if (out_valid && out_ready && expq.size() > 0) void'(expq.pop_front());
            if (in_valid && in_ready) expq.push_back(model(in_op, in_a, in_b));
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checkOutput("pending_ops", 32'(expq.size()), 32'd1);
            checkOutput("in_ready_while_done", 32'(in_ready), 32'd0);
            if (expq.size() > 0) begin
                checkOutput("model_y", 32'(out_y), 32'(expq[0].y));
                checkOutput("model_carry", 32'(out_carry), 32'(expq[0].c));
                checkOutput("model_flags", 32'({out_lt, out_eq, out_gt}),
                            32'({expq[0].lt, expq[0].eq, expq[0].gt}));
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] ey, input logic ec, input logic [2:0] eflags,
                                 input logic [1:0] ecin, input logic [1:0] esin);
        int       lat;
        int       wait_cnt;
        logic [1:0] cin_seen;
        logic [1:0] sin_seen;
        @(negedge clk);
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        wait_cnt  = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        cin_seen = '0;
        sin_seen = '0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            if (lat == 1) begin cin_seen[0] = slice_cin; sin_seen[0] = slice_sin; end
            if (lat == 2) begin cin_seen[1] = slice_cin; sin_seen[1] = slice_sin; end
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'd3);
        checkOutput("vec_y", 32'(out_y), 32'(ey));
        checkOutput("vec_carry", 32'(out_carry), 32'(ec));
        checkOutput("vec_flags", 32'({out_lt, out_eq, out_gt}), 32'(eflags));
        checkOutput("pass_cin", 32'(cin_seen), 32'(ecin));
        checkOutput("pass_sin", 32'(sin_seen), 32'(esin));
        @(posedge clk);
        @(negedge clk);
        checkOutput("in_ready_after_done", 32'(in_ready), 32'd1);
        checkOutput("out_valid_after_done", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int wait_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out", 32'({out_y, out_carry, out_lt, out_eq, out_gt}), 32'd0);
        checkOutput("reset_slice", 32'({slice_op, slice_a, slice_b, slice_cin, slice_sin}), 32'd0);

        // flags are {lt, eq, gt}; per-pass vectors hold pass 1 in bit 1, pass 0 in bit 0
        applyStimulus(3'd0, 8'h3C, 8'h4F, 8'h8B, 1'b0, 3'b100, 2'b10, 2'b00);
        applyStimulus(3'd1, 8'h20, 8'h21, 8'hFF, 1'b0, 3'b100, 2'b01, 2'b00);
        applyStimulus(3'd1, 8'h21, 8'h21, 8'h00, 1'b1, 3'b010, 2'b11, 2'b00);
        applyStimulus(3'd1, 8'h10, 8'h01, 8'h0F, 1'b1, 3'b001, 2'b01, 2'b00);
        applyStimulus(3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 3'b001, 2'b10, 2'b00);
        applyStimulus(3'd6, 8'h96, 8'h00, 8'h2C, 1'b1, 3'b001, 2'b00, 2'b00);
        applyStimulus(3'd7, 8'h96, 8'hFF, 8'h4B, 1'b0, 3'b100, 2'b00, 2'b01);
        applyStimulus(3'd2, 8'hA5, 8'h3C, 8'h24, 1'b0, 3'b001, 2'b00, 2'b00);
        applyStimulus(3'd3, 8'hA5, 8'h3C, 8'hBD, 1'b0, 3'b001, 2'b00, 2'b00);
        applyStimulus(3'd4, 8'hA5, 8'h3C, 8'h99, 1'b0, 3'b001, 2'b00, 2'b00);
        applyStimulus(3'd5, 8'hA5, 8'h3C, 8'h5A, 1'b0, 3'b001, 2'b00, 2'b00);
        applyStimulus(3'd2, 8'h5A, 8'h4B, 8'h4A, 1'b0, 3'b001, 2'b00, 2'b00);
        applyStimulus(3'd3, 8'h37, 8'h3A, 8'h3F, 1'b0, 3'b100, 2'b00, 2'b00);

        // Hold the consumer off while a new request keeps knocking.
        @(negedge clk);
        in_op     = 3'd0;
        in_a      = 8'h12;
        in_b      = 8'h34;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_op    = 3'd3;
        in_a     = 8'hFF;
        in_b     = 8'h00;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_hold_y", 32'(out_y), 32'h46);
            checkOutput("bp_hold_flags", 32'({out_carry, out_lt, out_eq, out_gt}), 32'b0100);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Reset arrives during pass 0 of an ADD.
        in_op    = 3'd0;
        in_a     = 8'h3C;
        in_b     = 8'h4F;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("mid_run_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_out", 32'({out_y, out_carry, out_lt, out_eq, out_gt}), 32'd0);
        checkOutput("rst_mid_slice", 32'({slice_op, slice_a, slice_b, slice_cin, slice_sin}), 32'd0);
        applyStimulus(3'd0, 8'h3C, 8'h4F, 8'h8B, 1'b0, 3'b100, 2'b10, 2'b00);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
